// File: rtl/seven_seg_arbiter.sv
// Seven-segment display arbiter: round-robin ownership with a minimum dwell,
// plus per-requester leading-zero blanking and blinking of the shown value.
module seven_seg_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 5000000,
  parameter int unsigned BLINK_CYCLES = 2500000
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [32*NUM_REQ-1:0]  i_data,
  input  logic [8*NUM_REQ-1:0]   i_dots,
  input  logic [NUM_REQ-1:0]     i_blankLz,
  input  logic [NUM_REQ-1:0]     i_blink,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [31:0]            o_data,
  output logic [7:0]             o_enableDigit,
  output logic [7:0]             o_dots
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]  BLINK_MAX = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] own_q, own_d, nxt;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [31:0]      data_q, data_d, sel_data;
  logic [7:0]       en_q, en_d, dots_q, dots_d, sel_dots;
  logic             sel_lz, sel_blink, seen;

  // First requester after base, wrapping around and ending at base itself.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] pick, cand;
    logic             found;
    int unsigned      idx;
    pick  = base;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(base) + k) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // own_q doubles as the round-robin pointer: in IDLE it keeps the last owner.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    dwell_d = dwell_q + DW_W'(1);
    nxt     = rr_pick(i_req, own_q);
    case (state_q)
      IDLE: begin
        dwell_d = '0;
        if (|i_req) begin
          state_d = SHOW;
          own_d   = nxt;
        end
      end
      SHOW: begin
        if (!i_req[own_q]) begin
          dwell_d = '0;
          if (|i_req) own_d = nxt;
          else        state_d = IDLE;
        end else if (dwell_q == DWELL_MAX) begin
          dwell_d = '0;
          own_d   = nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BL_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Display stage follows the registered grant, one cycle behind it.
  always_comb begin
    grant_d = '0;
    if (state_q == SHOW) grant_d[own_q] = 1'b1;

    sel_data  = '0;
    sel_dots  = '0;
    sel_lz    = 1'b0;
    sel_blink = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data  = i_data[32*k +: 32];
        sel_dots  = i_dots[8*k +: 8];
        sel_lz    = i_blankLz[k];
        sel_blink = i_blink[k];
      end
    end

    data_d = sel_data;
    dots_d = sel_dots;
    en_d   = '0;
    seen   = 1'b0;
    if (|grant_q) begin
      en_d = 8'hFF;
      if (sel_lz) begin
        for (int unsigned i = 7; i >= 1; i--) begin
          seen    = seen | (|sel_data[4*i +: 4]);
          en_d[i] = seen;
        end
      end
      if (sel_blink && phase_q) begin
        en_d   = '0;
        dots_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q     <= IDLE;
      own_q       <= LAST_INIT;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      grant_q     <= '0;
      data_q      <= '0;
      en_q        <= '0;
      dots_q      <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      en_q        <= en_d;
      dots_q      <= dots_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_data        = data_q;
  assign o_enableDigit = en_q;
  assign o_dots        = dots_q;
endmodule

// File: doc/seven_seg_arbiter.md
# seven_seg_arbiter

Shares the 8-digit seven-segment display between up to `NUM_REQ` requesters, such as the CPU output register, the debug/PC view and the error code. It feeds the display driver's `data`/`enableDigit`/`dots` inputs. Arbitration is round-robin with a guaranteed minimum dwell time per owner. The block also provides per-requester leading-zero blanking and blinking.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `DWELL_CYCLES`, default 5000000: minimum cycles an owner holds the display while others wait (1 s at 5 MHz).
- `BLINK_CYCLES`, default 2500000: half-period of the blink phase, in cycles.

Ports:
- `i_clk` in 1: 5 MHz clock; the only clock.
- `i_resetn` in 1: reset, synchronous, active-low.
- `i_req` in NUM_REQ: request per requester; held high while the requester wants the display.
- `i_data` in 32*NUM_REQ: 8 hex nibbles per requester; requester k occupies bits [32k+31:32k]; nibble i is digit i.
- `i_dots` in 8*NUM_REQ: decimal-point mask per requester.
- `i_blankLz` in NUM_REQ: leading-zero blanking enable per requester.
- `i_blink` in NUM_REQ: blink enable per requester.
- `o_grant` out NUM_REQ: one-hot current owner; all zero when idle.
- `o_data` out 32: to display driver `data`.
- `o_enableDigit` out 8: to display driver `enableDigit`.
- `o_dots` out 8: to display driver `dots`.

## Operation
- **States:**
  - IDLE: no owner.
  - SHOW: owner index `own` is valid.
- **Round-robin pointer `last`:** holds the most recent owner. The search order for the next owner is last+1, last+2, … modulo NUM_REQ, and includes `last` itself as the final candidate.
- **IDLE → SHOW:** when any `i_req` bit is high, grant the first requester in search order and clear the dwell counter.
- **SHOW, owner drops `i_req[own]`:**
  - If other requests are pending, grant the next one in search order starting at own+1.
  - Otherwise go to IDLE.
  - The dwell counter is cleared in both cases.
- **SHOW, dwell counter = DWELL_CYCLES-1:**
  - If another request is pending, switch to the next requester in search order.
  - If none is pending, keep the owner and wrap the counter to 0.
- **Simultaneous events:** an owner drop in the same cycle as dwell expiry follows the drop rule. New requests never preempt the owner before dwell expiry.
- **Display mux:** selects the owner's `i_data` and `i_dots`. In IDLE: `o_data` = 0, `o_enableDigit` = 0, `o_dots` = 0.
- **Leading-zero blanking:**
  - When `i_blankLz[own]` = 1, digit i (i ≥ 1) is enabled only if some nibble j ≥ i is nonzero.
  - Digit 0 is always enabled, so all-zero data shows a single "0".
  - When `i_blankLz[own]` = 0, all 8 digits are enabled.
  - `o_dots` is not affected by blanking.
- **Blink:**
  - A free-running counter toggles `phase` every BLINK_CYCLES cycles. It runs in every state.
  - While `i_blink[own]` = 1 and `phase` = 1, `o_enableDigit` = 0 and `o_dots` = 0.
- **Reset (any cycle, including mid-dwell):**
  - state IDLE, `last` = NUM_REQ-1 (so requester 0 wins first), dwell counter 0, blink counter 0, `phase` 0.
  - All outputs 0.

## Timing
- All outputs are registered.
- Request high in IDLE at edge n: `o_grant` is valid after edge n+1, and `o_data`/`o_enableDigit`/`o_dots` reflect that owner after edge n+2.
- Owner data changes while granted appear on the outputs 1 cycle after they are sampled.
- Contended ownership: the owner whose `o_grant` first asserts at cycle g holds it through cycle g+DWELL_CYCLES-1. The next grant appears at g+DWELL_CYCLES.
- Owner drop sampled at edge n: the new `o_grant` (or 0) appears after edge n+1.
- `o_grant` is never multi-hot and never glitches between states.
- Counter widths: at least ceil(log2(DWELL_CYCLES)) and ceil(log2(BLINK_CYCLES)) bits. No overflow is permitted.

## Test plan
Parameters for all tests: NUM_REQ=4, DWELL_CYCLES=8, BLINK_CYCLES=4.

1. **Reset then single request:** reset, then raise `i_req`=0001 with data 0x0000_1234 and blankLz=0 → `o_grant`=0001 one cycle later; next cycle `o_data`=0x00001234, `o_enableDigit`=0xFF.
2. **Rotation:** hold `i_req`=0111 from reset → grants 0001, 0010, 0100, 0001, …, each held exactly 8 cycles.
3. **Early drop:**
   - Owner 1 drops at dwell count 3 while req 3 pending → `o_grant`=1000 next cycle.
   - Then drop all requests → `o_grant`=0000 and `o_enableDigit`=0x00.
4. **Blanking:** owner data 0x0000_0A05 with blankLz=1 → `o_enableDigit`=0x07; data 0 → 0x01; data 0x8000_0000 → 0xFF.
5. **Blink:** owner with blink=1, dots=0x10 → `o_enableDigit`/`o_dots` alternate between full value and 0x00 every 4 cycles.
6. **Reset mid-dwell:** pulse `i_resetn` low during contention (req=1111, owner 2) → all outputs 0 next edge; after release, requester 0 is granted first.
